// File: rtl/hd44780_pkg.sv
// Shared types and default timing for the HD44780 4-bit read sequencer.
package hd44780_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_HI_EH,
      ST_HI_EL,
      ST_LO_EH,
      ST_LO_EL,
      ST_DONE
   } state_t;

   localparam int STATE_TIMER_BITS  = 8;
   localparam int DEF_SETUP_CYCLES  = 2;
   localparam int DEF_E_HIGH_CYCLES = 12;
   localparam int DEF_E_LOW_CYCLES  = 12;
   localparam int DEF_POLL_MAX      = 255;

   // The timer counts down to zero, so a phase of N cycles loads N-1.
   function automatic logic [STATE_TIMER_BITS-1:0] phase_load(input int cycles);
      return STATE_TIMER_BITS'(cycles - 1);
   endfunction

endpackage

// File: rtl/state_timer.sv
// Down-counter shared by every bus phase; expired marks the last cycle of a phase.
module state_timer
   import hd44780_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        load,
   input  logic [STATE_TIMER_BITS-1:0] load_value,
   output logic                        expired
);

   logic [STATE_TIMER_BITS-1:0] count_q;
   logic [STATE_TIMER_BITS-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_value;
      end else if (count_q != '0) begin
         count_d = count_q - STATE_TIMER_BITS'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired = (count_q == '0);

endmodule

// File: rtl/hd44780_reader.sv
// Reads one byte (two nibbles) from an HD44780 in 4-bit mode, optionally
// repeating busy-flag reads until BF clears or the poll budget runs out.
module hd44780_reader
   import hd44780_pkg::*;
#(
   parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
   parameter int E_HIGH_CYCLES = DEF_E_HIGH_CYCLES,
   parameter int E_LOW_CYCLES  = DEF_E_LOW_CYCLES,
   parameter int POLL_MAX      = DEF_POLL_MAX
) (
   input  logic       CLK_I,
   input  logic       RST_I,
   input  logic       start_strobe,
   input  logic       rs_sel,
   input  logic       poll_mode,
   input  logic [3:0] lcd_data_i,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_e,
   output logic       lcd_data_oe,
   output logic [7:0] DAT_O,
   output logic       busy,
   output logic       end_strobe,
   output logic       timeout
);

   localparam int               CNT_W      = (POLL_MAX < 2) ? 1 : $clog2(POLL_MAX + 1);
   localparam logic [CNT_W-1:0] POLL_LIMIT = CNT_W'(POLL_MAX);

   state_t                      state_q, state_d;
   logic                        rs_q, rs_d;
   logic                        rw_q, rw_d;
   logic                        e_q, e_d;
   logic                        busy_q, busy_d;
   logic                        end_q, end_d;
   logic                        timeout_q, timeout_d;
   logic                        poll_q, poll_d;
   logic [3:0]                  hi_nib_q, hi_nib_d;
   logic [3:0]                  lo_nib_q, lo_nib_d;
   logic [7:0]                  dat_q, dat_d;
   logic [CNT_W-1:0]            read_cnt_q, read_cnt_d;
   logic                        tmr_load;
   logic [STATE_TIMER_BITS-1:0] tmr_value;
   logic                        tmr_expired;

   state_timer u_state_timer (
      .clk        (CLK_I),
      .rst        (RST_I),
      .load       (tmr_load),
      .load_value (tmr_value),
      .expired    (tmr_expired)
   );

   // Outputs are computed for the state being entered, so every pin is a flop.
   always_comb begin
      state_d    = state_q;
      rs_d       = rs_q;
      rw_d       = rw_q;
      e_d        = e_q;
      end_d      = 1'b0;
      timeout_d  = timeout_q;
      poll_d     = poll_q;
      hi_nib_d   = hi_nib_q;
      lo_nib_d   = lo_nib_q;
      dat_d      = dat_q;
      read_cnt_d = read_cnt_q;
      tmr_load   = 1'b0;
      tmr_value  = '0;

      case (state_q)
         ST_IDLE: begin
            if (start_strobe) begin
               state_d    = ST_SETUP;
               rs_d       = rs_sel;
               rw_d       = 1'b1;
               poll_d     = poll_mode & ~rs_sel;
               read_cnt_d = CNT_W'(1);
               tmr_load   = 1'b1;
               tmr_value  = phase_load(SETUP_CYCLES);
            end
         end
         ST_SETUP: begin
            if (tmr_expired) begin
               state_d   = ST_HI_EH;
               e_d       = 1'b1;
               tmr_load  = 1'b1;
               tmr_value = phase_load(E_HIGH_CYCLES);
            end
         end
         ST_HI_EH: begin
            if (tmr_expired) begin
               state_d   = ST_HI_EL;
               hi_nib_d  = lcd_data_i;
               e_d       = 1'b0;
               tmr_load  = 1'b1;
               tmr_value = phase_load(E_LOW_CYCLES);
            end
         end
         ST_HI_EL: begin
            if (tmr_expired) begin
               state_d   = ST_LO_EH;
               e_d       = 1'b1;
               tmr_load  = 1'b1;
               tmr_value = phase_load(E_HIGH_CYCLES);
            end
         end
         ST_LO_EH: begin
            if (tmr_expired) begin
               state_d   = ST_LO_EL;
               lo_nib_d  = lcd_data_i;
               e_d       = 1'b0;
               tmr_load  = 1'b1;
               tmr_value = phase_load(E_LOW_CYCLES);
            end
         end
         ST_LO_EL: begin
            if (tmr_expired) begin
               // BF is bit 7 of the byte just read, i.e. the top bit of the high nibble.
               if (poll_q && hi_nib_q[3] && (read_cnt_q < POLL_LIMIT)) begin
                  state_d   = ST_HI_EH;
                  e_d       = 1'b1;
                  tmr_load  = 1'b1;
                  tmr_value = phase_load(E_HIGH_CYCLES);
                  if (read_cnt_q != '1) begin
                     read_cnt_d = read_cnt_q + CNT_W'(1);
                  end
               end else begin
                  state_d   = ST_DONE;
                  dat_d     = {hi_nib_q, lo_nib_q};
                  end_d     = 1'b1;
                  rw_d      = 1'b0;
                  timeout_d = poll_q & hi_nib_q[3];
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            rw_d    = 1'b0;
            e_d     = 1'b0;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         state_q    <= ST_IDLE;
         rs_q       <= 1'b0;
         rw_q       <= 1'b0;
         e_q        <= 1'b0;
         busy_q     <= 1'b0;
         end_q      <= 1'b0;
         timeout_q  <= 1'b0;
         poll_q     <= 1'b0;
         hi_nib_q   <= 4'h0;
         lo_nib_q   <= 4'h0;
         dat_q      <= 8'h00;
         read_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         rs_q       <= rs_d;
         rw_q       <= rw_d;
         e_q        <= e_d;
         busy_q     <= busy_d;
         end_q      <= end_d;
         timeout_q  <= timeout_d;
         poll_q     <= poll_d;
         hi_nib_q   <= hi_nib_d;
         lo_nib_q   <= lo_nib_d;
         dat_q      <= dat_d;
         read_cnt_q <= read_cnt_d;
      end
   end

   assign lcd_rs      = rs_q;
   assign lcd_rw      = rw_q;
   assign lcd_e       = e_q;
   assign lcd_data_oe = 1'b0;
   assign DAT_O       = dat_q;
   assign busy        = busy_q;
   assign end_strobe  = end_q;
   assign timeout     = timeout_q;

endmodule

// File: tb/tb_hd44780_reader.sv
// Self-checking bench: an LCD model serves nibbles per E pulse and the
// expected byte, read count, latency and timeout come from the read rules.
module tb_hd44780_reader;

   localparam int SETUP_TB    = 2;
   localparam int EH_TB       = 12;
   localparam int EL_TB       = 12;
   localparam int POLL_MAX_TB = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       startStrobe;
   logic       rsSel;
   logic       pollMode;
   logic [3:0] lcdData;
   logic       lcdRs;
   logic       lcdRw;
   logic       lcdE;
   logic       lcdDataOe;
   logic [7:0] datO;
   logic       busy;
   logic       endStrobe;
   logic       timeout;

   int         checks   = 0;
   int         failures = 0;

   logic [7:0] respMem [0:7];
   int         ePulses   = 0;
   int         pulseBase = 0;
   int         relPulse;
   logic [2:0] readIdx;

   hd44780_reader #(
      .SETUP_CYCLES  (SETUP_TB),
      .E_HIGH_CYCLES (EH_TB),
      .E_LOW_CYCLES  (EL_TB),
      .POLL_MAX      (POLL_MAX_TB)
   ) dut (
      .CLK_I        (clk),
      .RST_I        (rst),
      .start_strobe (startStrobe),
      .rs_sel       (rsSel),
      .poll_mode    (pollMode),
      .lcd_data_i   (lcdData),
      .lcd_rs       (lcdRs),
      .lcd_rw       (lcdRw),
      .lcd_e        (lcdE),
      .lcd_data_oe  (lcdDataOe),
      .DAT_O        (datO),
      .busy         (busy),
      .end_strobe   (endStrobe),
      .timeout      (timeout)
   );

   always #5 clk = ~clk;

   // Each falling E edge completes one nibble transfer on the LCD side.
   always @(negedge lcdE) ePulses <= ePulses + 1;

   // The LCD presents the high nibble of read k on pulse 2k, the low nibble on 2k+1.
   always_comb begin
      relPulse = ePulses - pulseBase;
      readIdx  = relPulse[3:1];
      lcdData  = relPulse[0] ? respMem[readIdx][3:0] : respMem[readIdx][7:4];
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Reads stop at the first byte with BF=0, or after POLL_MAX reads.
   function automatic int expectedReads(input logic rsArg, input logic pollArg);
      if (!pollArg || rsArg) return 1;
      for (int i = 0; i < POLL_MAX_TB; i++) begin
         if (respMem[i][7] == 1'b0) return i + 1;
      end
      return POLL_MAX_TB;
   endfunction

   task automatic applyStimulus(input string tag, input logic rsArg, input logic pollArg, input int extraAt);
      int         reads, expLat, budget;
      int         endCycle, endCount, rises, firstRise, runLen;
      int         rwBad, rsBad, oeBad, busyBad, highBad, lowBad;
      logic       prevE, rwAtEnd, busyAfter, strobeAfter, expTimeout;
      logic [7:0] expData;

      reads      = expectedReads(rsArg, pollArg);
      expData    = respMem[reads-1];
      expTimeout = pollArg && !rsArg && expData[7];
      expLat     = SETUP_TB + reads * 2 * (EH_TB + EL_TB) + 1;
      budget     = expLat + 10;

      endCycle = -1; endCount = 0; rises = 0; firstRise = -1; runLen = 0;
      rwBad = 0; rsBad = 0; oeBad = 0; busyBad = 0; highBad = 0; lowBad = 0;
      prevE = 1'b0; rwAtEnd = 1'b1; busyAfter = 1'b1; strobeAfter = 1'b1;

      @(negedge clk);
      pulseBase   = ePulses;
      rsSel       = rsArg;
      pollMode    = pollArg;
      startStrobe = 1'b1;
      @(posedge clk);
      #1 startStrobe = 1'b0;

      for (int cyc = 1; cyc <= budget; cyc++) begin
         @(negedge clk);
         if (lcdDataOe !== 1'b0) oeBad++;
         if (endStrobe === 1'b1) begin
            endCount++;
            if (endCycle < 0) begin
               endCycle = cyc;
               rwAtEnd  = lcdRw;
            end
         end
         if (endCycle < 0) begin
            if (lcdRw !== 1'b1) rwBad++;
            if (lcdRs !== rsArg) rsBad++;
         end
         if ((endCycle < 0 || cyc == endCycle) && busy !== 1'b1) busyBad++;
         if (lcdE === 1'b1 && prevE === 1'b0) begin
            rises++;
            if (firstRise < 0) firstRise = cyc;
            else if (runLen != EL_TB) lowBad++;
            runLen = 0;
         end else if (lcdE === 1'b0 && prevE === 1'b1) begin
            if (runLen != EH_TB) highBad++;
            runLen = 0;
         end
         runLen++;
         prevE = lcdE;
         if (cyc == extraAt) begin
            startStrobe = 1'b1;
            rsSel       = ~rsArg;
            pollMode    = ~pollArg;
         end else if (cyc == extraAt + 1) begin
            startStrobe = 1'b0;
         end
         if (endCycle >= 0 && cyc == endCycle + 1) begin
            busyAfter   = busy;
            strobeAfter = endStrobe;
            break;
         end
      end

      checkOutput({tag, " end_cycle"}, 32'(endCycle), 32'(expLat));
      checkOutput({tag, " end_count"}, 32'(endCount), 32'd1);
      checkOutput({tag, " e_pulses"}, 32'(rises), 32'(2 * reads));
      checkOutput({tag, " first_e_rise"}, 32'(firstRise), 32'(SETUP_TB + 1));
      checkOutput({tag, " e_high_width_errs"}, 32'(highBad), 32'd0);
      checkOutput({tag, " e_low_width_errs"}, 32'(lowBad), 32'd0);
      checkOutput({tag, " rw_low_in_read"}, 32'(rwBad), 32'd0);
      checkOutput({tag, " rs_changed"}, 32'(rsBad), 32'd0);
      checkOutput({tag, " oe_driven"}, 32'(oeBad), 32'd0);
      checkOutput({tag, " busy_low_in_read"}, 32'(busyBad), 32'd0);
      checkOutput({tag, " rw_at_done"}, 32'(rwAtEnd), 32'd0);
      checkOutput({tag, " busy_after"}, 32'(busyAfter), 32'd0);
      checkOutput({tag, " strobe_after"}, 32'(strobeAfter), 32'd0);
      checkOutput({tag, " dat_o"}, 32'(datO), 32'(expData));
      checkOutput({tag, " timeout"}, 32'(timeout), 32'(expTimeout));
      rsSel    = 1'b0;
      pollMode = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int endSeen;
      logic [7:0] b;

      for (int i = 0; i < 8; i++) respMem[i] = 8'h00;
      rst         = 1'b1;
      startStrobe = 1'b0;
      rsSel       = 1'b0;
      pollMode    = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset dat_o", 32'(datO), 32'h00);
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset lcd_e", 32'(lcdE), 32'd0);
      checkOutput("reset lcd_rw", 32'(lcdRw), 32'd0);
      checkOutput("reset lcd_rs", 32'(lcdRs), 32'd0);
      checkOutput("reset oe", 32'(lcdDataOe), 32'd0);
      checkOutput("reset end_strobe", 32'(endStrobe), 32'd0);
      checkOutput("reset timeout", 32'(timeout), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Abort in the middle of the low-nibble E pulse.
      $display("[TB] reset during LO_EH");
      respMem[0] = 8'h5A;
      @(negedge clk);
      pulseBase   = ePulses;
      rsSel       = 1'b1;
      startStrobe = 1'b1;
      @(posedge clk);
      #1 startStrobe = 1'b0;
      repeat (30) @(negedge clk);
      checkOutput("abort pre lcd_e", 32'(lcdE), 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("abort lcd_e", 32'(lcdE), 32'd0);
      checkOutput("abort busy", 32'(busy), 32'd0);
      checkOutput("abort lcd_rw", 32'(lcdRw), 32'd0);
      checkOutput("abort lcd_rs", 32'(lcdRs), 32'd0);
      checkOutput("abort dat_o", 32'(datO), 32'h00);
      endSeen = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (endStrobe !== 1'b0) endSeen++;
      end
      rst   = 1'b0;
      rsSel = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (endStrobe !== 1'b0) endSeen++;
      end
      checkOutput("abort end_strobe", 32'(endSeen), 32'd0);
      checkOutput("abort dat_o after", 32'(datO), 32'h00);

      $display("[TB] data read");
      respMem[0] = 8'hA5;
      applyStimulus("data_a5", 1'b1, 1'b0, -10);

      $display("[TB] busy poll stuck");
      for (int i = 0; i < 8; i++) respMem[i] = 8'h85;
      applyStimulus("poll_stuck", 1'b0, 1'b1, -10);

      $display("[TB] busy poll clears");
      respMem[0] = 8'h8C; respMem[1] = 8'hC1; respMem[2] = 8'hFF; respMem[3] = 8'h27;
      applyStimulus("poll_clear", 1'b0, 1'b1, -10);

      $display("[TB] second strobe mid-read");
      respMem[0] = 8'h3C;
      applyStimulus("restrobe", 1'b1, 1'b0, 10);

      $display("[TB] randomized reads");
      for (int t = 0; t < 8; t++) begin
         for (int i = 0; i < 8; i++) begin
            b          = 8'($urandom);
            b[7]       = ($urandom_range(0, 9) < 6);
            respMem[i] = b;
         end
         applyStimulus($sformatf("rand%0d", t), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -10);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
